data_memory_stage: RTL and testbench

//   Memory-access stage (4_memory), directly downstream of the execute-stage ALU.
//   - Consumes the ALU result as a byte address and register data_2 as store data.
//   - Performs LDUR/STUR against an internal word-addressed RAM.
//   - Emulates a multi-cycle memory; stalls the pipeline through busy.
//   - Reports illegal accesses on fault.

---
 rtl/data_memory_stage.sv | 126 ++++++++++++
 tb/tb_data_memory_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_stage.sv
// Memory-access stage: performs LDUR/STUR on an internal word RAM that answers LATENCY edges after a request is accepted.
// Define MEM_ALIGN_CHECK_EN to make addresses that are not word aligned raise fault.
`ifndef WORD
`define WORD 64
`endif

module data_memory_stage #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [`WORD-1:0] address,
  input  logic [`WORD-1:0] write_data,
  output logic [`WORD-1:0] read_data,
  output logic             busy,
  output logic             done,
  output logic             fault
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_write_q, op_write_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [`WORD-1:0] wdata_q, wdata_d;
  logic [`WORD-1:0] read_data_q, read_data_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;

  logic [`WORD-1:0] mem [DEPTH];

  logic [`WORD-4:0] word_addr;
  logic             in_range, aligned, one_op, any_req, legal_req, complete;

  assign word_addr = address[`WORD-1:3];
  assign in_range  = (word_addr >> IDX_W) == '0;
  assign one_op    = mem_read ^ mem_write;
  assign any_req   = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
  assign aligned = (address[2:0] == 3'b000);
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^address[2:0];
  assign aligned          = 1'b1;
`endif

  assign legal_req = one_op && in_range && aligned;
  assign complete  = (state_q == BUSY) && (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_write_d  = op_write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal_req) begin
          op_write_d = mem_write;
          idx_d      = word_addr[IDX_W-1:0];
          wdata_d    = write_data;
          cnt_d      = CNT_INIT;
          state_d    = BUSY;
        end else if (any_req) begin
          fault_d = 1'b1;
        end
      end
      BUSY: begin
        // Inputs are deliberately ignored here; only the latched request matters.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!op_write_q) read_data_d = mem[idx_q];
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_write_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_write_q  <= op_write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  // RAM is never cleared; a reset on the completion edge suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!reset && complete && op_write_q) mem[idx_q] <= wdata_q;
  end

  assign busy      = !reset && ((state_q == BUSY) || legal_req);
  assign read_data = read_data_q;
  assign done      = done_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_data_memory_stage.sv
// Self-checking bench for data_memory_stage: directed vector table, hand sequences and random requests
// checked against an array-based memory model. Honours MEM_ALIGN_CHECK_EN when defined.
`ifndef WORD
`define WORD 64
`endif

module tb_data_memory_stage;

  localparam int DEPTH     = 128;
  localparam int LATENCY   = 2;
  localparam int MAX_EDGES = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_read, mem_write;
  logic [`WORD-1:0] address, write_data;
  logic [`WORD-1:0] read_data;
  logic             busy, done, fault;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [`WORD-1:0] model_mem [DEPTH];
  bit               model_valid [DEPTH];
  logic [`WORD-1:0] model_rdata;
  bit               rdata_known;

  typedef struct {
    bit               rd;
    bit               wr;
    logic [`WORD-1:0] addr;
    logic [`WORD-1:0] wdata;
    bit               exp_fault;
    logic [`WORD-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  data_memory_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [`WORD-1:0] actual,
                             input logic [`WORD-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic bit isLegal(input bit rd, input bit wr, input logic [`WORD-1:0] addr);
    bit ok;
    ok = (rd != wr) && ((addr >> 3) < DEPTH);
`ifdef MEM_ALIGN_CHECK_EN
    if ((addr % 8) != 0) ok = 1'b0;
`endif
    return ok;
  endfunction

  // Presents one request at a negedge and follows it until done/fault or the cycle bound.
  task automatic applyStimulus(input string name, input bit rd, input bit wr,
                               input logic [`WORD-1:0] addr, input logic [`WORD-1:0] wdata,
                               output bit fault_seen);
    bit legal, illegal, saw_done, saw_fault;
    int exp_edges, limit, edges, busy_cycles, idx;
    legal     = isLegal(rd, wr, addr);
    illegal   = (rd || wr) && !legal;
    exp_edges = legal ? LATENCY + 1 : (illegal ? 1 : LATENCY + 2);
    limit     = (legal || illegal) ? MAX_EDGES : exp_edges;
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wdata;
    #1;
    checkOutput({name, " busy_now"}, busy, legal);
    busy_cycles = busy ? 1 : 0;
    edges     = 0;
    saw_done  = 1'b0;
    saw_fault = 1'b0;
    while (edges < limit && !saw_done && !saw_fault) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      saw_done  = done;
      saw_fault = fault;
      if (busy) busy_cycles++;
      if (legal && edges < LATENCY && !saw_done && !saw_fault) begin
        mem_read   = 1'($urandom);
        mem_write  = 1'($urandom);
        address    = {$urandom, $urandom};
        write_data = {$urandom, $urandom};
      end else begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
      end
    end
    fault_seen = saw_fault;
    checkOutput({name, " edges"}, edges, exp_edges);
    checkOutput({name, " done"}, saw_done, legal);
    checkOutput({name, " fault"}, saw_fault, illegal);
    checkOutput({name, " busy_cycles"}, busy_cycles, legal ? LATENCY + 1 : 0);
    if (legal) begin
      idx = int'(addr >> 3);
      if (wr) begin
        model_mem[idx]   = wdata;
        model_valid[idx] = 1'b1;
      end else begin
        rdata_known = model_valid[idx];
        model_rdata = model_mem[idx];
      end
    end
    if (rdata_known) checkOutput({name, " read_data"}, read_data, model_rdata);
  endtask

  task automatic checkIdle(input string name);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " idle_done"}, done, 1'b0);
    checkOutput({name, " idle_fault"}, fault, 1'b0);
    checkOutput({name, " idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    bit f;
    bit rd, wr;
    int r, word, lsb;
    logic [`WORD-1:0] a;

    vecs[0]  = '{1'b0, 1'b1, `WORD'(8),    `WORD'(25), 1'b0, `WORD'(0)};
    vecs[1]  = '{1'b1, 1'b0, `WORD'(8),    `WORD'(0),  1'b0, `WORD'(25)};
    vecs[2]  = '{1'b0, 1'b1, `WORD'(16),   `WORD'(15), 1'b0, `WORD'(25)};
    vecs[3]  = '{1'b1, 1'b0, `WORD'(16),   `WORD'(0),  1'b0, `WORD'(15)};
    vecs[4]  = '{1'b1, 1'b1, `WORD'(8),    `WORD'(77), 1'b1, `WORD'(15)};
    vecs[5]  = '{1'b1, 1'b0, `WORD'(8),    `WORD'(0),  1'b0, `WORD'(25)};
    vecs[6]  = '{1'b1, 1'b0, `WORD'(1024), `WORD'(0),  1'b1, `WORD'(25)};
`ifdef MEM_ALIGN_CHECK_EN
    vecs[7]  = '{1'b1, 1'b0, `WORD'(12),   `WORD'(0),  1'b1, `WORD'(25)};
`else
    vecs[7]  = '{1'b1, 1'b0, `WORD'(12),   `WORD'(0),  1'b0, `WORD'(25)};
`endif
    vecs[8]  = '{1'b0, 1'b1, `WORD'(24),   `WORD'(5),  1'b0, `WORD'(25)};
    vecs[9]  = '{1'b1, 1'b0, `WORD'(24),   `WORD'(0),  1'b0, `WORD'(5)};
    vecs[10] = '{1'b0, 1'b0, `WORD'(32),   `WORD'(9),  1'b0, `WORD'(5)};

    for (int i = 0; i < DEPTH; i++) model_valid[i] = 1'b0;
    model_rdata = '0;
    rdata_known = 1'b1;

    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset read_data", read_data, '0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset fault", fault, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, f);
      checkOutput($sformatf("vec%0d tbl_fault", i), f, vecs[i].exp_fault);
      checkOutput($sformatf("vec%0d tbl_rdata", i), read_data, vecs[i].exp_rdata);
      checkIdle($sformatf("vec%0d", i));
    end

    // Back-to-back: the load is presented in the done cycle of the store.
    applyStimulus("b2b_st", 1'b0, 1'b1, `WORD'(40), `WORD'(7), f);
    applyStimulus("b2b_ld", 1'b1, 1'b0, `WORD'(40), `WORD'(0), f);
    checkOutput("b2b value", read_data, `WORD'(7));
    checkIdle("b2b");

    // Reset while BUSY aborts the pending store to word 3.
    mem_write  = 1'b1;
    address    = `WORD'(24);
    write_data = `WORD'(99);
    @(posedge clk);
    @(negedge clk);
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    checkOutput("abort busy", busy, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort read_data", read_data, '0);
    checkOutput("abort done", done, 1'b0);
    checkOutput("abort fault", fault, 1'b0);
    checkOutput("abort busy_rst", busy, 1'b0);
    @(negedge clk);
    reset       = 1'b0;
    model_rdata = '0;
    rdata_known = 1'b1;
    applyStimulus("abort_ld", 1'b1, 1'b0, `WORD'(24), `WORD'(0), f);
    checkOutput("abort kept", read_data, `WORD'(5));
    checkIdle("abort");

    for (int n = 0; n < 40; n++) begin
      r    = $urandom_range(0, 9);
      rd   = (r < 4) || (r == 8);
      wr   = (r >= 4 && r < 8) || (r == 8);
      word = $urandom_range(0, DEPTH + 3);
      lsb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      a    = (`WORD'(word) << 3) | `WORD'(lsb);
      applyStimulus($sformatf("rnd%0d", n), rd, wr, a, {$urandom, $urandom}, f);
      if ($urandom_range(0, 1) == 1) checkIdle($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
